// File: rtl/jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// jk_cmd_driver
//   Command stage in front of a jk_ff. A command is taken over a
//   valid/ready handshake. The driver then holds the command's {j,k} pattern
//   on the flop's inputs for the programmed number of cycles. While it does
//   so it tracks the flop's expected q in its own reference model and counts
//   how often the fed-back q disagrees with that model.
//
// Parameters
//   CW  width of cmd_count (drive cycles per command)
//   EW  width of err_count (saturating mismatch counter)
//
// Ports
//   clk        single clock, all state on its rising edge
//   rst        asynchronous, active-high reset
//   cmd_valid  command present, held by the source until accepted
//   cmd_ready  high only while idle
//   cmd_op     {j,k}: 00 HOLD, 01 RESET, 10 SET, 11 TOGGLE
//   cmd_count  number of cycles to drive cmd_op
//   j, k       registered drive to the jk_ff
//   q_in       q fed back from the jk_ff
//   done       one-cycle pulse when a command completes
//   pass       valid with done: model known and no mismatches
//   q_known    reference model holds a defined value
//   err_count  mismatches of the current/last command, saturating
// ---------------------------------------------------------------------------
module jk_cmd_driver #(
    parameter int CW = 8,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic [CW-1:0] cmd_count,
    output logic          j,
    output logic          k,
    input  logic          q_in,
    output logic          done,
    output logic          pass,
    output logic          q_known,
    output logic [EW-1:0] err_count
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic [1:0]    state;
    logic [1:0]    op_r;
    logic [CW-1:0] cnt;       // drive cycles still to go, including the current one
    logic          first;     // current DRIVE cycle is D1 (jk_ff has not seen j/k yet)
    logic          q_model;

    logic          accept;
    logic          cmp_en;
    logic          mismatch;
    logic [EW-1:0] err_next;

    assign cmd_ready = (state == S_IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // In D1 the flop has not clocked the new j/k yet, so q_in says nothing
    // about this command; compares start in D2 and end with the CHECK cycle.
    assign cmp_en   = q_known && (((state == S_DRIVE) && !first) || (state == S_CHECK));
    assign mismatch = cmp_en && (q_in != q_model);

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        err_next = err_count;
        if (mismatch && !(&err_count)) begin
            err_next = err_count + EW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so every right-hand
    // side reads the value from before the edge (the model update and the
    // compare in the same DRIVE cycle both rely on this).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            op_r      <= OP_HOLD;
            cnt       <= '0;
            first     <= 1'b0;
            q_model   <= 1'b0;
            q_known   <= 1'b0;
            j         <= 1'b0;
            k         <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
        end else begin
            done <= 1'b0;
            pass <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r      <= cmd_op;
                        cnt       <= cmd_count;
                        first     <= 1'b1;
                        err_count <= '0;
                        if (cmd_count == '0) begin
                            state <= S_CHECK;
                        end else begin
                            state <= S_DRIVE;
                            j     <= cmd_op[1];
                            k     <= cmd_op[0];
                        end
                    end
                end

                S_DRIVE: begin
                    err_count <= err_next;
                    first     <= 1'b0;

                    // The jk_ff clocks j/k on this same edge; keep the model in step.
                    case (op_r)
                        OP_RESET: begin
                            q_model <= 1'b0;
                            q_known <= 1'b1;
                        end
                        OP_SET: begin
                            q_model <= 1'b1;
                            q_known <= 1'b1;
                        end
                        OP_TOGGLE: q_model <= ~q_model;
                        default:   q_model <= q_model;
                    endcase

                    if (cnt == CW'(1)) begin
                        state <= S_CHECK;
                        j     <= 1'b0;
                        k     <= 1'b0;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end

                S_CHECK: begin
                    err_count <= err_next;
                    done      <= 1'b1;
                    pass      <= q_known && (err_next == '0);
                    state     <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    j     <= 1'b0;
                    k     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_jk_cmd_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_cmd_driver
//   Drives commands into jk_cmd_driver and plays the part of the jk_ff:
//   a behavioural flop (random power-up value) that follows the commanded
//   pattern. Selected cycles have q_in inverted to provoke mismatches. For
//   each command the expected done cycle, pass, err_count and q_known are
//   worked out from the command rules and queued. A separate monitor pops
//   and compares whenever done is seen.
// ---------------------------------------------------------------------------
module tb_jk_cmd_driver;

    localparam int CW      = 8;
    localparam int EW      = 3;
    localparam int ERR_MAX = (1 << EW) - 1;

    localparam logic [1:0] OP_HOLD   = 2'b00;
    localparam logic [1:0] OP_RESET  = 2'b01;
    localparam logic [1:0] OP_SET    = 2'b10;
    localparam logic [1:0] OP_TOGGLE = 2'b11;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [CW-1:0] cmd_count;
    logic          j;
    logic          k;
    logic          q_in;
    logic          done;
    logic          pass;
    logic          q_known;
    logic [EW-1:0] err_count;

    jk_cmd_driver #(.CW(CW), .EW(EW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_count (cmd_count),
        .j         (j),
        .k         (k),
        .q_in      (q_in),
        .done      (done),
        .pass      (pass),
        .q_known   (q_known),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit pass_e;
        int err_e;
        bit known_e;
        int cyc_e;
    } exp_t;

    exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    bit phys;      // the emulated jk_ff's real q
    bit known0;    // whether the reference knows q before the next command
    int last_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every done pulse against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'(done), 32'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_cycle", 32'(cyc), 32'(e.cyc_e));
                check("pass", 32'(pass), 32'(e.pass_e));
                check("err_count", 32'(err_count), 32'(e.err_e));
                check("q_known", 32'(q_known), 32'(e.known_e));
            end
        end
    end

    task automatic do_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'b00;
        cmd_count = '0;
        q_in      = 1'b0;
        #1;
        check("rst_ready", 32'(cmd_ready), 32'(1));
        check("rst_jk", 32'({j, k}), 32'(0));
        check("rst_done_pass", 32'({done, pass}), 32'(0));
        check("rst_known", 32'(q_known), 32'(0));
        check("rst_err", 32'(err_count), 32'(0));
        phys     = 1'($urandom);
        known0   = 1'b0;
        last_err = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Idle cycles between commands; called and returns on a negedge.
    task automatic idle(input int g);
        for (int c = 0; c < g; c++) begin
            cmd_valid = 1'b0;
            q_in      = phys;
            check("idle_ready", 32'(cmd_ready), 32'(1));
            check("idle_jk", 32'({j, k}), 32'(0));
            check("err_hold", 32'(err_count), 32'(last_err));
            @(negedge clk);
        end
    endtask

    // Issue one command starting at a negedge with the DUT idle; returns on
    // the negedge of the cycle where done is due. flip[i] inverts q_in in
    // the i-th cycle after accept (cycles 1..n drive, n+1 is CHECK).
    task automatic run_cmd(input logic [1:0] op, input int n, input logic [31:0] flip,
                           input bit keep_valid, input logic [1:0] nop, input int nn);
        int errs;
        bit kn_i;
        bit known_f;
        exp_t e;

        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_count = n[CW-1:0];
        q_in      = phys;
        check("ready_at_issue", 32'(cmd_ready), 32'(1));

        // Reference: q becomes known after the first drive of RESET/SET.
        // Compares happen in every cycle after the first drive cycle, and
        // in the single CHECK cycle when there are no drive cycles.
        errs = 0;
        for (int i = 1; i <= n + 1; i++) begin
            kn_i = (i == 1) ? known0 : (known0 || op == OP_RESET || op == OP_SET);
            if (kn_i && (i >= 2 || n == 0) && flip[i]) errs++;
        end
        known_f  = known0 || (n > 0 && (op == OP_RESET || op == OP_SET));
        e.err_e   = (errs > ERR_MAX) ? ERR_MAX : errs;
        e.known_e = known_f;
        e.pass_e  = known_f && (errs == 0);
        e.cyc_e   = cyc + n + 2;
        sb.push_back(e);

        @(posedge clk);
        for (int i = 1; i <= n + 1; i++) begin
            @(negedge clk);
            if (keep_valid) begin
                cmd_valid = 1'b1;
                cmd_op    = nop;
                cmd_count = nn[CW-1:0];
            end else begin
                cmd_valid = 1'b0;
                cmd_op    = 2'($urandom);
                cmd_count = CW'($urandom);
            end
            q_in = phys ^ flip[i];
            check("busy_ready", 32'(cmd_ready), 32'(0));
            if (i <= n) check("drive_jk", 32'({j, k}), 32'(op));
            else        check("check_jk", 32'({j, k}), 32'(0));
            @(posedge clk);
            if (i <= n) begin
                case (op)
                    OP_RESET:  phys = 1'b0;
                    OP_SET:    phys = 1'b1;
                    OP_TOGGLE: phys = ~phys;
                    default:   phys = phys;
                endcase
            end
        end
        @(negedge clk);
        known0   = known_f;
        last_err = e.err_e;
    endtask

    logic [1:0]  r_op[41];
    int          r_n[41];
    logic [31:0] r_flip[41];
    bit          r_keep[41];
    int          r_gap[41];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Directed: SET 3, then TOGGLE 4 from a known 1.
        run_cmd(OP_SET, 3, 32'h0, 1'b0, OP_HOLD, 0);
        idle(1);
        run_cmd(OP_TOGGLE, 4, 32'h0, 1'b0, OP_HOLD, 0);
        idle(1);

        // TOGGLE from an unknown model: flips must not be counted.
        do_reset();
        run_cmd(OP_TOGGLE, 2, 32'hFFFF_FFFF, 1'b0, OP_HOLD, 0);
        idle(1);

        // SET with q_in stuck opposite: 5 errors, then saturation.
        run_cmd(OP_SET, 5, 32'hFFFF_FFFF, 1'b0, OP_HOLD, 0);
        idle(1);
        run_cmd(OP_SET, 12, 32'hFFFF_FFFF, 1'b0, OP_HOLD, 0);
        idle(2);

        // count=0 HOLD, with the next command held valid while busy.
        run_cmd(OP_HOLD, 0, 32'h0, 1'b1, OP_RESET, 2);
        run_cmd(OP_RESET, 2, 32'h0, 1'b0, OP_HOLD, 0);
        run_cmd(OP_HOLD, 0, 32'h2, 1'b0, OP_HOLD, 0);
        idle(1);

        // Reset in the 2nd drive cycle of RESET count=6: no done afterwards.
        cmd_valid = 1'b1;
        cmd_op    = OP_RESET;
        cmd_count = CW'(6);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk);
        phys = 1'b0;
        @(negedge clk);
        q_in = phys;
        #2;
        rst = 1'b1;
        #1;
        check("midrst_jk", 32'({j, k}), 32'(0));
        check("midrst_ready", 32'(cmd_ready), 32'(1));
        check("midrst_known", 32'(q_known), 32'(0));
        check("midrst_done", 32'(done), 32'(0));
        known0   = 1'b0;
        last_err = 0;
        @(negedge clk);
        rst = 1'b0;
        idle(4);

        // Random commands.
        for (int i = 0; i < 41; i++) begin
            int mode;
            r_op[i] = 2'($urandom);
            r_n[i]  = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 12);
            mode    = $urandom_range(0, 3);
            if (mode == 0)      r_flip[i] = 32'hFFFF_FFFF;
            else if (mode == 1) r_flip[i] = $urandom & $urandom;
            else                r_flip[i] = 32'h0;
            r_keep[i] = ($urandom_range(0, 3) == 0);
            r_gap[i]  = $urandom_range(0, 2);
        end
        for (int i = 0; i < 40; i++) begin
            run_cmd(r_op[i], r_n[i], r_flip[i], r_keep[i], r_op[i+1], r_n[i+1]);
            if (!r_keep[i]) idle(r_gap[i]);
        end

        idle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
